mm_feeder: RTL and testbench

MM_FEEDER -- requirements
Module: mm_feeder

---
 rtl/mm_pkg.sv | 36 +++
 rtl/mm_feeder_operand_bank.sv | 45 ++++
 rtl/mm_feeder.sv | 166 ++++++++++++++++
 tb/tb_mm_feeder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared constants, FSM encoding and beat-timing helpers for the matrix feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mm_pkg;

  localparam int N            = 4;
  localparam int DEF_MULT_LAT = 2;
  localparam int DEF_ADD_LAT  = 2;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One beat = multiply window + add window + one output cycle.
  function automatic int beat_len(input int mult_lat, input int add_lat);
    return mult_lat + add_lat + 1;
  endfunction

  // Skewed wavefront through an NxN array needs 3N-2 beats to drain.
  function automatic int num_beats(input int n);
    return 3 * n - 2;
  endfunction

  // Enables for phase p of a beat, packed as {mult_en, add_en, out_en}.
  function automatic logic [2:0] phase_en(input int p, input int mult_lat, input int add_lat);
    return {p < mult_lat,
            (p >= mult_lat) && (p < mult_lat + add_lat),
            p == mult_lat + add_lat};
  endfunction

endpackage

// File: rtl/mm_feeder_operand_bank.sv
// NxN x 32 operand register file: one write port, every element readable in parallel.
// Latency: write visible on rd_data the cycle after the wr_en edge; reads are combinational.
// Backpressure: none; every strobed write is taken.
//   clk, reset (async active-low, clears all entries)
//   wr_en, wr_row, wr_col, wr_data : write port
//   rd_data : element (r,c) at bits [32*(r*N+c) +: 32]
module operand_bank
  import mm_pkg::FP_ZERO;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [$clog2(N)-1:0]   wr_col,
  input  logic [31:0]            wr_data,
  output logic [N*N*32-1:0]      rd_data
);

  localparam int IW = $clog2(N);

  logic [31:0] mem [N][N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mem[r][c] <= FP_ZERO;
    end else begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (wr_en && (wr_row == IW'(r)) && (wr_col == IW'(c)))
            mem[r][c] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        rd_data[32*(r*N+c) +: 32] = mem[r][c];
  end

endmodule

// File: rtl/mm_feeder.sv
// Sequences an NxN FP32 matrix multiply through a systolic comp_unit array: skewed operands plus broadcast enables.
// Latency: CLEAR 1 cycle, RUN (3N-2)*BEAT cycles, DONE 1 cycle after the start cycle (52 cycles for defaults).
// Backpressure: none; start is ignored unless IDLE, writes are ignored in CLEAR/RUN.
//   clk, reset (async active-low)
//   start, wr_en/wr_sel/wr_row/wr_col/wr_data : control and operand load (wr_sel 0 = A, 1 = B)
//   ovf_in : per-cell overflow from the array, folded into sticky ovf_flag
//   a_out (row i lane), b_out (column j lane), mult_en/add_en/out_en/arr_clr : array drive
//   busy, done, ovf_flag : status
module mm_feeder #(
  parameter int N        = mm_pkg::N,
  parameter int MULT_LAT = mm_pkg::DEF_MULT_LAT,
  parameter int ADD_LAT  = mm_pkg::DEF_ADD_LAT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [31:0]          wr_data,
  input  logic [N*N-1:0]       ovf_in,
  output logic [N*32-1:0]      a_out,
  output logic [N*32-1:0]      b_out,
  output logic                 mult_en,
  output logic                 add_en,
  output logic                 out_en,
  output logic                 arr_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf_flag
);

  import mm_pkg::FP_ZERO;
  import mm_pkg::state_t;
  import mm_pkg::ST_IDLE;
  import mm_pkg::ST_CLEAR;
  import mm_pkg::ST_RUN;
  import mm_pkg::ST_DONE;
  import mm_pkg::beat_len;
  import mm_pkg::num_beats;
  import mm_pkg::phase_en;

  localparam int BEAT   = beat_len(MULT_LAT, ADD_LAT);
  localparam int NBEATS = num_beats(N);
  localparam int PH_W   = (BEAT > 1) ? $clog2(BEAT) : 1;
  localparam int BT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [BT_W-1:0]   beat;

  logic              bank_we;
  logic [N*N*32-1:0] a_flat;
  logic [N*N*32-1:0] b_flat;
  logic [BT_W-1:0]   load_beat;
  logic [N*32-1:0]   a_skew;
  logic [N*32-1:0]   b_skew;

  // Banks are only writable while the array is not being fed.
  assign bank_we = wr_en && ((state == ST_IDLE) || (state == ST_DONE));

  operand_bank #(.N(N)) u_bank_a (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bank_we && !wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_data (a_flat)
  );

  operand_bank #(.N(N)) u_bank_b (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bank_we && wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_data (b_flat)
  );

  // Operands are registered on the edge that enters phase 0, so the skew
  // is computed for the beat about to start: 0 when leaving CLEAR, else beat+1.
  assign load_beat = (state == ST_RUN) ? beat + 1'b1 : '0;

  // Element (i,j) lands on A lane i and B lane j during beat i+j; every
  // other lane carries +0.0.
  always_comb begin
    a_skew = {N{FP_ZERO}};
    b_skew = {N{FP_ZERO}};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (int'(load_beat) == i + j) begin
          a_skew[32*i +: 32] = a_flat[32*(i*N+j) +: 32];
          b_skew[32*j +: 32] = b_flat[32*(i*N+j) +: 32];
        end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      phase    <= '0;
      beat     <= '0;
      a_out    <= '0;
      b_out    <= '0;
      mult_en  <= 1'b0;
      add_en   <= 1'b0;
      out_en   <= 1'b0;
      arr_clr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_CLEAR;
            arr_clr  <= 1'b1;
            busy     <= 1'b1;
            ovf_flag <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state                     <= ST_RUN;
          arr_clr                   <= 1'b0;
          phase                     <= '0;
          beat                      <= '0;
          {mult_en, add_en, out_en} <= phase_en(0, MULT_LAT, ADD_LAT);
          a_out                     <= a_skew;
          b_out                     <= b_skew;
        end
        ST_RUN: begin
          if (|ovf_in)
            ovf_flag <= 1'b1;
          if (phase == PH_W'(BEAT - 1)) begin
            phase <= '0;
            if (beat == BT_W'(NBEATS - 1)) begin
              state                     <= ST_DONE;
              beat                      <= '0;
              busy                      <= 1'b0;
              done                      <= 1'b1;
              {mult_en, add_en, out_en} <= 3'b000;
              a_out                     <= '0;
              b_out                     <= '0;
            end else begin
              beat                      <= beat + 1'b1;
              {mult_en, add_en, out_en} <= phase_en(0, MULT_LAT, ADD_LAT);
              a_out                     <= a_skew;
              b_out                     <= b_skew;
            end
          end else begin
            phase                     <= phase + 1'b1;
            {mult_en, add_en, out_en} <= phase_en(int'(phase) + 1, MULT_LAT, ADD_LAT);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_feeder.sv
module tb_mm_feeder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         wr_en = 1'b0;
  logic         wr_sel = 1'b0;
  logic [1:0]   wr_row = '0;
  logic [1:0]   wr_col = '0;
  logic [31:0]  wr_data = '0;
  logic [15:0]  ovf_in = '0;
  logic [127:0] a_out;
  logic [127:0] b_out;
  logic         mult_en, add_en, out_en, arr_clr, busy, done, ovf_flag;

  mm_feeder dut (
    .clk(clk), .reset(reset), .start(start), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .ovf_in(ovf_in),
    .a_out(a_out), .b_out(b_out), .mult_en(mult_en), .add_en(add_en),
    .out_en(out_en), .arr_clr(arr_clr), .busy(busy), .done(done), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    int           k;
  } beat_t;

  beat_t       sb_q[$];
  logic [31:0] ma [4][4];
  logic [31:0] mb [4][4];
  int          errors = 0;
  int          checks = 0;
  int          oe_count = 0;

  // FP32 encodings of 0.0 .. 15.0
  logic [31:0] fp_tab [16] = '{
    32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
    32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
    32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
    32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t model_beat(input int k);
    beat_t e;
    e.a = '0;
    e.b = '0;
    e.k = k;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i + j == k) begin
          e.a[32*i +: 32] = ma[i][j];
          e.b[32*j +: 32] = mb[i][j];
        end
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
  endtask

  // Drive a write strobe; update the model only when the write should land.
  task automatic wr(input logic sel, input int r, input int c, input logic [31:0] d, input bit update);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = r[1:0];
    wr_col  = c[1:0];
    wr_data = d;
    if (update) begin
      if (sel) mb[r][c] = d;
      else     ma[r][c] = d;
    end
  endtask

  // All stimulus tasks enter and leave 1ns after a rising edge.
  task automatic do_write(input logic sel, input int r, input int c, input logic [31:0] d);
    wr(sel, r, c, d, 1'b1);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard monitor: every out_en cycle must match the next queued beat.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && out_en) begin
        oe_count++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: out_en with no expected beat queued");
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          check($sformatf("beat%0d_a_out", e.k), {128'h0, a_out}, {128'h0, e.a});
          check($sformatf("beat%0d_b_out", e.k), {128'h0, b_out}, {128'h0, e.b});
        end
      end
    end
  end

  task automatic run(input bit co_wr, input int dir, input bit done_wr,
                     input bit ovf_poke, input bit rst_b4);
    logic [6:0] exp_v;
    int         p;
    int         n_done;
    int         n_busy;
    // cycle 0: start (optionally with a coincident B[0][0] write)
    start = 1'b1;
    if (co_wr) wr(1'b1, 0, 0, 32'h3F800000, 1'b1);
    sb_q.delete();
    oe_count = 0;
    for (int k = 0; k < 10; k++) sb_q.push_back(model_beat(k));
    @(posedge clk); #1;
    for (int c = 1; c <= 53; c++) begin
      start  = 1'b0;
      wr_en  = 1'b0;
      ovf_in = '0;
      if (ovf_poke && c == 1)  wr(1'b1, 3, 3, 32'hBAD0BAD0, 1'b0);
      if (ovf_poke && c == 19) ovf_in = 16'h0020;
      if (ovf_poke && c == 30) begin
        start = 1'b1;
        wr(1'b0, 0, 0, 32'hDEADBEEF, 1'b0);
      end
      if (done_wr && c == 52) wr(1'b0, 1, 1, 32'h42000000, 1'b1);
      if (rst_b4 && c == 22) begin
        reset = 1'b0;
        #1;
        check("rst_midrun_ctl", {arr_clr, busy, done, mult_en, add_en, out_en, ovf_flag}, 7'd0);
        check("rst_midrun_ops", {a_out, b_out}, 256'h0);
        sb_q.delete();
        clear_model();
        @(posedge clk); #1;
        reset = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int w = 0; w < 60; w++) begin
          @(negedge clk);
          if (done) n_done++;
          if (busy) n_busy++;
          @(posedge clk); #1;
        end
        check("rst_no_done", n_done, 0);
        check("rst_stays_idle", n_busy, 0);
        return;
      end
      @(negedge clk);
      exp_v = '0;
      exp_v[6] = (c == 1);
      exp_v[5] = (c >= 1 && c <= 51);
      exp_v[4] = (c == 52);
      if (c >= 2 && c <= 51) begin
        p = (c - 2) % 5;
        exp_v[3] = (p < 2);
        exp_v[2] = (p >= 2 && p < 4);
        exp_v[1] = (p == 4);
      end
      exp_v[0] = ovf_poke && (c >= 20);
      check($sformatf("ctl_c%0d", c),
            {arr_clr, busy, done, mult_en, add_en, out_en, ovf_flag}, exp_v);
      if (c == 1 || c == 52 || c == 53)
        check($sformatf("ops_zero_c%0d", c), {a_out, b_out}, 256'h0);
      if (dir == 1 && c == 2) begin
        check("beat0_a_lanes", a_out, {96'h0, 32'h3F800000});
        check("beat0_b_lanes", b_out, {96'h0, 32'h3F800000});
      end
      if (dir == 2 && c == 27) begin
        check("beat5_a2", a_out[95:64], 32'h41300000);
        check("beat5_a3", a_out[127:96], 32'h41600000);
        check("beat5_a0", a_out[31:0], 32'h0);
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    check("out_en_pulses", oe_count, 10);
    check("beats_consumed", sb_q.size(), 0);
  endtask

  initial begin
    clear_model();
    // reset held: everything quiet
    idle(2);
    check("reset_ctl", {arr_clr, busy, done, mult_en, add_en, out_en, ovf_flag}, 7'd0);
    check("reset_ops", {a_out, b_out}, 256'h0);
    reset = 1'b1;
    idle(2);

    // single 1.0 in A[0][0]; B[0][0] written in the start cycle itself
    do_write(1'b0, 0, 0, 32'h3F800000);
    run(1'b1, 1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // full load A = i*4+j, B = 15-(i*4+j); a write during DONE must land
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        do_write(1'b0, i, j, fp_tab[i*4+j]);
        do_write(1'b1, i, j, fp_tab[15-(i*4+j)]);
      end
    run(1'b0, 2, 1'b1, 1'b0, 1'b0);
    idle(2);

    // overflow outside RUN is not recorded
    ovf_in = 16'hFFFF;
    idle(1);
    ovf_in = '0;
    @(negedge clk);
    check("ovf_idle_ignored", ovf_flag, 1'b0);
    @(posedge clk); #1;

    // overflow in beat 3, plus start/write pokes during CLEAR/RUN
    run(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(3);
    @(negedge clk);
    check("ovf_sticky_idle", ovf_flag, 1'b1);
    @(posedge clk); #1;

    // next start clears the flag (checked per cycle inside run)
    run(1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // reset at beat 4 aborts; banks clear; then a full fresh run
    run(1'b0, 0, 1'b0, 1'b0, 1'b1);
    do_write(1'b0, 2, 1, 32'h40400000);
    run(1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
